// File: rtl/spart_pkg.sv
// Shared SPART definitions: transmit FSM states, baud rates and the bit-period divisor helper.
// Imported by both the transmit and receive paths.
package spart_pkg;

    localparam int DATA_W     = 8;
    localparam int BAUD_CNT_W = 15;

    localparam int unsigned BAUD_4800  = 4800;
    localparam int unsigned BAUD_9600  = 9600;
    localparam int unsigned BAUD_19200 = 19200;
    localparam int unsigned BAUD_38400 = 38400;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    // Rounded bit period in clk cycles: (clk_hz + baud/2) / baud.
    function automatic logic [BAUD_CNT_W-1:0] div_for(input logic [1:0] cfg, input int unsigned clk_hz);
        int unsigned baud;
        case (cfg)
            2'b00:   baud = BAUD_4800;
            2'b01:   baud = BAUD_9600;
            2'b10:   baud = BAUD_19200;
            default: baud = BAUD_38400;
        endcase
        return BAUD_CNT_W'((clk_hz + baud / 2) / baud);
    endfunction

endpackage

// File: rtl/spart_baud_tick.sv
// Loadable down-counter producing one tick on the last cycle of every bit period.
// A load restarts the period; otherwise the counter reloads itself from the last loaded divisor.
module spart_baud_tick
    import spart_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [BAUD_CNT_W-1:0] div,
    output logic                  tick
);

    localparam logic [BAUD_CNT_W-1:0] ONE = BAUD_CNT_W'(1);

    logic [BAUD_CNT_W-1:0] cnt_q, cnt_d;
    logic [BAUD_CNT_W-1:0] period_q, period_d;

    always_comb begin
        cnt_d    = cnt_q;
        period_d = period_q;
        if (load) begin
            cnt_d    = div - ONE;
            period_d = div;
        end else if (cnt_q == '0) begin
            cnt_d = period_q - ONE;
        end else begin
            cnt_d = cnt_q - ONE;
        end
    end

    // A period of 1 keeps the counter parked at zero until the first load.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q    <= '0;
            period_q <= ONE;
        end else begin
            cnt_q    <= cnt_d;
            period_q <= period_d;
        end
    end

    assign tick = (cnt_q == '0);

endmodule

// File: rtl/spart_tx.sv
// SPART transmitter: valid/ready byte intake into a one-entry holding buffer, 8N1 serialisation.
// Handshake: a byte is taken on any rising edge where tx_valid && tx_ready; tx_ready = hold empty.
module spart_tx
    import spart_pkg::*;
#(
    parameter int unsigned CLK_HZ = 100000000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        br_cfg,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              txd,
    output logic              tx_busy
);

    tx_state_t             state_q, state_d;
    logic [2:0]            bit_idx_q, bit_idx_d;
    logic [DATA_W-1:0]     shift_q, shift_d;
    logic [DATA_W-1:0]     hold_q, hold_d;
    logic                  hold_full_q, hold_full_d;
    logic                  txd_q, txd_d;
    logic                  baud_load;
    logic                  baud_tick;
    logic [BAUD_CNT_W-1:0] baud_div;

    // br_cfg only matters on the cycle baud_load is high, i.e. when a frame starts.
    assign baud_div = div_for(br_cfg, CLK_HZ);

    spart_baud_tick u_baud (
        .clk  (clk),
        .rst  (rst),
        .load (baud_load),
        .div  (baud_div),
        .tick (baud_tick)
    );

    always_comb begin
        state_d     = state_q;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        txd_d       = txd_q;
        baud_load   = 1'b0;

        case (state_q)
            IDLE: begin
                txd_d = 1'b1;
                if (hold_full_q) begin
                    shift_d     = hold_q;
                    hold_full_d = 1'b0;
                    baud_load   = 1'b1;
                    txd_d       = 1'b0;
                    state_d     = START;
                end
            end
            START: begin
                if (baud_tick) begin
                    bit_idx_d = '0;
                    txd_d     = shift_q[0];
                    state_d   = DATA;
                end
            end
            DATA: begin
                if (baud_tick) begin
                    if (bit_idx_q == 3'(DATA_W - 1)) begin
                        txd_d   = 1'b1;
                        state_d = STOP;
                    end else begin
                        shift_d   = {1'b0, shift_q[DATA_W-1:1]};
                        txd_d     = shift_q[1];
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
            STOP: begin
                if (baud_tick) begin
                    // A waiting byte starts its frame with no idle cycle in between.
                    if (hold_full_q) begin
                        shift_d     = hold_q;
                        hold_full_d = 1'b0;
                        baud_load   = 1'b1;
                        txd_d       = 1'b0;
                        state_d     = START;
                    end else begin
                        txd_d   = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                txd_d   = 1'b1;
                state_d = IDLE;
            end
        endcase

        // Intake never coincides with a pickup: one needs hold empty, the other hold full.
        if (tx_valid && !hold_full_q) begin
            hold_d      = tx_data;
            hold_full_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            txd_q       <= 1'b1;
        end else begin
            state_q     <= state_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            txd_q       <= txd_d;
        end
    end

    assign tx_ready = !hold_full_q;
    assign tx_busy  = (state_q != IDLE);
    assign txd      = txd_q;

endmodule

// File: tb/tb_spart_tx.sv
// Bench for spart_tx: per-cycle line model built from whole frames, a mid-bit frame decoder
// with an expected-byte queue, directed scenarios with literal expectations, then random traffic.
module tb_spart_tx;
    import spart_pkg::*;

    localparam int unsigned CLK_HZ = 1000000;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] br_cfg = 2'b01;
    logic [7:0] tx_data = 8'h5A;
    logic       tx_valid = 1'b1;
    logic       tx_ready;
    logic       txd;
    logic       tx_busy;

    spart_tx #(.CLK_HZ(CLK_HZ)) dut (
        .clk      (clk),
        .rst      (rst),
        .br_cfg   (br_cfg),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .txd      (txd),
        .tx_busy  (tx_busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            if (bad <= 40) $display("FAIL %s: got=%0d want=%0d at %0t", name, got, want, $time);
        end
    endtask

    function automatic int baud_of(input logic [1:0] c);
        case (c)
            2'd0:    return 4800;
            2'd1:    return 9600;
            2'd2:    return 19200;
            default: return 38400;
        endcase
    endfunction

    function automatic int model_div(input logic [1:0] c);
        return (int'(CLK_HZ) + baud_of(c) / 2) / baud_of(c);
    endfunction

    // Line model: m_wave holds the txd level for the current and every remaining cycle of the frame.
    bit         m_wave[$];
    logic [7:0] m_hold;
    bit         m_full = 1'b0;
    bit         m_ok = 1'b0;
    int         m_epoch = 0;
    int         m_accepts = 0;
    int         m_dropped = 0;
    logic [7:0] exp_q[$];
    int         div_q[$];
    bit         full_pre;
    int         frame_div;
    logic [9:0] frame_bits;

    always @(posedge clk) begin
        if (rst) begin
            m_dropped += exp_q.size();
            m_wave.delete();
            exp_q.delete();
            div_q.delete();
            m_full = 1'b0;
            m_epoch++;
            m_ok = 1'b1;
        end else begin
            full_pre = m_full;
            if (m_wave.size() > 0) void'(m_wave.pop_front());
            if (m_wave.size() == 0 && full_pre) begin
                frame_div  = model_div(br_cfg);
                frame_bits = {1'b1, m_hold, 1'b0};
                for (int b = 0; b < 10; b++)
                    for (int k = 0; k < frame_div; k++) m_wave.push_back(frame_bits[b]);
                div_q.push_back(frame_div);
                m_full = 1'b0;
            end
            if (tx_valid && !full_pre) begin
                m_hold = tx_data;
                m_full = 1'b1;
                exp_q.push_back(tx_data);
                m_accepts++;
            end
        end
    end

    always @(negedge clk) begin
        if (m_ok) begin
            check("txd", {31'd0, txd}, (m_wave.size() > 0) ? {31'd0, m_wave[0]} : 32'd1);
            check("tx_ready", {31'd0, tx_ready}, {31'd0, !m_full});
            check("tx_busy", {31'd0, tx_busy}, {31'd0, m_wave.size() > 0});
        end
    end

    // Frame decoder: samples each bit at its centre and checks the byte against exp_q.
    int frames_seen = 0;

    initial begin : decoder
        int         d;
        int         ep;
        int         last_c;
        logic [9:0] fb;
        bit         aborted;
        logic [7:0] want;
        forever begin
            @(negedge clk);
            if (m_ok && !rst && txd === 1'b0) begin
                if (div_q.size() == 0) begin
                    check("spurious_start", 32'd1, 32'd0);
                end else begin
                    d       = div_q.pop_front();
                    ep      = m_epoch;
                    fb      = '0;
                    aborted = 1'b0;
                    last_c  = 9 * d + d / 2;
                    for (int c = 0; c <= last_c; c++) begin
                        if (m_epoch != ep || rst) aborted = 1'b1;
                        if (!aborted && (c % d) == d / 2) fb[c / d] = txd;
                        if (c != last_c) @(negedge clk);
                    end
                    if (m_epoch != ep) aborted = 1'b1;
                    if (!aborted) begin
                        frames_seen++;
                        check("start_bit", {31'd0, fb[0]}, 32'd0);
                        check("stop_bit", {31'd0, fb[9]}, 32'd1);
                        if (exp_q.size() == 0) begin
                            check("unexpected_frame", {24'd0, fb[8:1]}, 32'hFFFF_FFFF);
                        end else begin
                            want = exp_q.pop_front();
                            check("frame_byte", {24'd0, fb[8:1]}, {24'd0, want});
                        end
                    end
                end
            end
        end
    end

    // Called on a negedge; returns on the negedge right after the accept edge.
    task automatic send(input logic [7:0] b);
        int n;
        n = 0;
        tx_data  = b;
        tx_valid = 1'b1;
        while (tx_ready !== 1'b1 && n < 6000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 6000) check("send_timeout", 32'd0, 32'd1);
        @(negedge clk);
        tx_valid = 1'b0;
        tx_data  = 8'($urandom);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (!(tx_busy === 1'b0 && tx_ready === 1'b1) && n < 8000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 8000) check("idle_timeout", 32'd0, 32'd1);
        @(negedge clk);
    endtask

    function automatic logic [1:0] pick_cfg();
        int r;
        r = $urandom_range(0, 9);
        if (r == 0) return 2'd0;
        if (r < 3)  return 2'd1;
        if (r < 6)  return 2'd2;
        return 2'd3;
    endfunction

    initial begin : watchdog
        #1200000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "watchdog");
    end

    initial begin : main
        bit         cap[$];
        int         n;
        int         viol;
        int         seen0;
        logic [9:0] pat55;
        logic [1:0] cfgs[4];
        int         div_1m[4];
        int         div_100m[4];

        cfgs     = '{2'd0, 2'd1, 2'd2, 2'd3};
        div_1m   = '{208, 104, 52, 26};
        div_100m = '{20833, 10417, 5208, 2604};
        pat55    = 10'b1010101010;

        // Reset held with tx_valid high: nothing may be accepted or sent.
        repeat (4) @(negedge clk);
        check("rst_txd", {31'd0, txd}, 32'd1);
        check("rst_ready", {31'd0, tx_ready}, 32'd1);
        check("rst_busy", {31'd0, tx_busy}, 32'd0);
        rst      = 1'b0;
        tx_valid = 1'b0;
        @(negedge clk);
        check("post_rst_ready", {31'd0, tx_ready}, 32'd1);
        check("post_rst_busy", {31'd0, tx_busy}, 32'd0);

        for (int i = 0; i < 4; i++) begin
            check("model_div", model_div(cfgs[i]), div_1m[i]);
            check("pkg_div_100m", {17'd0, div_for(cfgs[i], 100000000)}, div_100m[i]);
        end

        // Single 0x55 at 9600: start one cycle after accept, 10 bits of 104 cycles.
        br_cfg = 2'b01;
        send(8'h55);
        check("lat_pre", {31'd0, txd}, 32'd1);
        @(negedge clk);
        check("lat_start", {31'd0, txd}, 32'd0);
        n = 0;
        while (tx_busy === 1'b1 && n < 5000) begin
            cap.push_back(txd);
            n++;
            @(negedge clk);
        end
        check("busy_len", n, 32'd1040);
        if (cap.size() == 1040) begin
            for (int b = 0; b < 10; b++) check("bit55", {31'd0, cap[b * 104 + 52]}, {31'd0, pat55[b]});
            viol = 0;
            for (int c = 1; c < 1040; c++) if (cap[c] != cap[c - 1] && (c % 104) != 0) viol++;
            check("edge_align", viol, 32'd0);
        end
        wait_idle();

        // Back-to-back 0x55, 0xAA: second frame follows the first stop bit directly.
        send(8'h55);
        send(8'hAA);
        n = 0;
        while (tx_busy === 1'b1 && n < 5000) begin
            n++;
            @(negedge clk);
        end
        check("b2b_busy", n, 32'd2079);
        wait_idle();

        // Baud change mid-frame only affects the next frame.
        br_cfg = 2'b11;
        send(8'hE3);
        repeat (50) @(negedge clk);
        br_cfg = 2'b00;
        send(8'h14);
        n = 0;
        while (tx_busy === 1'b1 && n < 5000) begin
            n++;
            @(negedge clk);
        end
        check("switch_busy", n, 32'd2290);
        wait_idle();

        // Reset during data bit 3 of 0x0F with a second byte waiting in hold.
        br_cfg = 2'b10;
        send(8'h0F);
        send(8'h77);
        repeat (228) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_txd", {31'd0, txd}, 32'd1);
        check("midrst_busy", {31'd0, tx_busy}, 32'd0);
        check("midrst_ready", {31'd0, tx_ready}, 32'd1);
        @(negedge clk);
        rst = 1'b0;
        seen0 = 0;
        for (int c = 0; c < 1200; c++) begin
            if (txd !== 1'b1 || tx_busy !== 1'b0) seen0++;
            @(negedge clk);
        end
        check("midrst_silent", seen0, 32'd0);

        // Backpressure: valid held with a constant byte for three frame slots.
        br_cfg   = 2'b11;
        tx_data  = 8'hC3;
        tx_valid = 1'b1;
        n        = frames_seen;
        viol     = 0;
        for (int c = 0; c < 300; c++) begin
            if (tx_ready === 1'b1) viol++;
            @(negedge clk);
        end
        tx_valid = 1'b0;
        check("bp_accepts", viol, 32'd3);
        wait_idle();
        repeat (30) @(negedge clk);
        check("bp_frames", frames_seen - n, 32'd3);

        // Random traffic with occasional mid-frame baud changes.
        for (int i = 0; i < 25; i++) begin
            if ($urandom_range(0, 3) == 0) br_cfg = pick_cfg();
            send(8'($urandom_range(0, 255)));
            if ($urandom_range(0, 4) == 0) br_cfg = pick_cfg();
            repeat ($urandom_range(0, 40)) @(negedge clk);
        end
        wait_idle();
        repeat (30) @(negedge clk);

        check("exp_q_empty", exp_q.size(), 32'd0);
        check("frames_total", frames_seen, m_accepts - m_dropped);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
